// File: rtl/y86_alu.sv
// Y86-64 execute-stage ALU: add/sub/and/xor on signed operands.
// Result and flags are registered, so they appear one clock after the operands.
module y86_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             zf,
    output logic             sf
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    logic [WIDTH-1:0] b_eff;
    logic             carry_in;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] out_d, out_q;
    logic             overflow_d, overflow_q;
    logic             zf_d, zf_q;
    logic             sf_d, sf_q;

    // Subtraction reuses the adder as a + ~b + 1.
    always_comb begin
        b_eff    = (control == OP_SUB) ? ~b : b;
        carry_in = (control == OP_SUB);
    end

    // Ripple-carry chain of 1-bit full adders; the final carry-out is dropped.
    always_comb begin
        logic c;
        sum = '0;
        c   = carry_in;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b_eff[i] ^ c;
            c      = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
        end
    end

    always_comb begin
        out_d      = '0;
        overflow_d = 1'b0;
        case (control)
            OP_ADD: begin
                out_d      = sum;
                overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                out_d      = sum;
                overflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  out_d = a & b;
            OP_XOR:  out_d = a ^ b;
            default: out_d = '0;
        endcase
        zf_d = (out_d == '0);
        sf_d = out_d[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= '0;
            overflow_q <= 1'b0;
            zf_q       <= 1'b1;
            sf_q       <= 1'b0;
        end else begin
            out_q      <= out_d;
            overflow_q <= overflow_d;
            zf_q       <= zf_d;
            sf_q       <= sf_d;
        end
    end

    assign out      = out_q;
    assign overflow = overflow_q;
    assign zf       = zf_q;
    assign sf       = sf_q;

endmodule

// File: tb/tb_y86_alu.sv
// Directed self-checking bench for y86_alu; each task checks one feature.
module tb_y86_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  control;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] out;
    logic        overflow;
    logic        zf;
    logic        sf;

    int check_count = 0;
    int pass_count  = 0;

    y86_alu #(.WIDTH(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .control  (control),
        .a        (a),
        .b        (b),
        .out      (out),
        .overflow (overflow),
        .zf       (zf),
        .sf       (sf)
    );

    always #5 clk = ~clk;

    // Apply one operation away from the edge, then sample just after the capturing edge.
    task automatic drive(input logic r, input logic [1:0] c, input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        reset   = r;
        control = c;
        a       = x;
        b       = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [66:0] obs;
        logic [66:0] exp;
        drive(1'b1, 2'b00, 64'd5, 64'd7);
        obs = {out, overflow, zf, sf};
        exp = {64'h0, 1'b0, 1'b1, 1'b0};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL reset: got %h want %h", obs, exp);
        else pass_count++;
    endtask

    task automatic test_add;
        logic [66:0] obs;
        logic [66:0] exp;
        drive(1'b0, 2'b00, 64'd5, 64'd7);
        obs = {out, overflow, zf, sf};
        exp = {64'd12, 1'b0, 1'b0, 1'b0};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL add_5_7: got %h want %h", obs, exp);
        else pass_count++;

        drive(1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        obs = {out, overflow, zf, sf};
        exp = {64'h0, 1'b0, 1'b1, 1'b0};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL add_m1_1: got %h want %h", obs, exp);
        else pass_count++;
    endtask

    task automatic test_sub;
        logic [66:0] obs;
        logic [66:0] exp;
        drive(1'b0, 2'b01, 64'h100, 64'd1);
        obs = {out, overflow, zf, sf};
        exp = {64'hFF, 1'b0, 1'b0, 1'b0};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL sub_stack: got %h want %h", obs, exp);
        else pass_count++;

        drive(1'b0, 2'b01, 64'd3, 64'd3);
        obs = {out, overflow, zf, sf};
        exp = {64'h0, 1'b0, 1'b1, 1'b0};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL sub_3_3: got %h want %h", obs, exp);
        else pass_count++;

        drive(1'b0, 2'b01, 64'd5, 64'd9);
        obs = {out, overflow, zf, sf};
        exp = {64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b1};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL sub_5_9: got %h want %h", obs, exp);
        else pass_count++;
    endtask

    task automatic test_overflow;
        logic [66:0] obs;
        logic [66:0] exp;
        drive(1'b0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        obs = {out, overflow, zf, sf};
        exp = {64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL add_ovf: got %h want %h", obs, exp);
        else pass_count++;

        drive(1'b0, 2'b01, 64'h8000_0000_0000_0000, 64'd1);
        obs = {out, overflow, zf, sf};
        exp = {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL sub_ovf: got %h want %h", obs, exp);
        else pass_count++;

        drive(1'b0, 2'b01, 64'h0, 64'h8000_0000_0000_0000);
        obs = {out, overflow, zf, sf};
        exp = {64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL sub_neg_min: got %h want %h", obs, exp);
        else pass_count++;

        drive(1'b0, 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        obs = {out, overflow, zf, sf};
        exp = {64'h0, 1'b1, 1'b1, 1'b0};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL add_min_min: got %h want %h", obs, exp);
        else pass_count++;
    endtask

    task automatic test_logic;
        logic [66:0] obs;
        logic [66:0] exp;
        drive(1'b0, 2'b10, 64'hF0F0, 64'hFF00);
        obs = {out, overflow, zf, sf};
        exp = {64'hF000, 1'b0, 1'b0, 1'b0};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL and: got %h want %h", obs, exp);
        else pass_count++;

        drive(1'b0, 2'b11, 64'hF0F0, 64'hFF00);
        obs = {out, overflow, zf, sf};
        exp = {64'h0FF0, 1'b0, 1'b0, 1'b0};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL xor: got %h want %h", obs, exp);
        else pass_count++;

        drive(1'b0, 2'b10, 64'h8000_0000_0000_00FF, 64'hFFFF_0000_0000_000F);
        obs = {out, overflow, zf, sf};
        exp = {64'h8000_0000_0000_000F, 1'b0, 1'b0, 1'b1};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL and_neg: got %h want %h", obs, exp);
        else pass_count++;

        drive(1'b0, 2'b11, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
        obs = {out, overflow, zf, sf};
        exp = {64'h0, 1'b0, 1'b1, 1'b0};
        check_count++;
        if (obs !== exp) $display("[TB] FAIL xor_zero: got %h want %h", obs, exp);
        else pass_count++;
    endtask

    task automatic test_back_to_back;
        logic        r_v [6];
        logic [1:0]  c_v [6];
        logic [63:0] a_v [6];
        logic [63:0] b_v [6];
        logic [66:0] e_v [6];
        logic [66:0] obs;
        r_v[0] = 1'b0; c_v[0] = 2'b00; a_v[0] = 64'd10;  b_v[0] = 64'd20;
        e_v[0] = {64'd30, 1'b0, 1'b0, 1'b0};
        r_v[1] = 1'b0; c_v[1] = 2'b01; a_v[1] = 64'd5;   b_v[1] = 64'd9;
        e_v[1] = {64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b1};
        r_v[2] = 1'b1; c_v[2] = 2'b00; a_v[2] = 64'd1;   b_v[2] = 64'd1;
        e_v[2] = {64'h0, 1'b0, 1'b1, 1'b0};
        r_v[3] = 1'b0; c_v[3] = 2'b10; a_v[3] = 64'hFF;  b_v[3] = 64'h0F;
        e_v[3] = {64'h0F, 1'b0, 1'b0, 1'b0};
        r_v[4] = 1'b0; c_v[4] = 2'b00; a_v[4] = 64'h7FFF_FFFF_FFFF_FFFF; b_v[4] = 64'd1;
        e_v[4] = {64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
        r_v[5] = 1'b0; c_v[5] = 2'b11; a_v[5] = 64'h1234; b_v[5] = 64'h00FF;
        e_v[5] = {64'h12CB, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(r_v[i], c_v[i], a_v[i], b_v[i]);
            obs = {out, overflow, zf, sf};
            check_count++;
            if (obs !== e_v[i]) $display("[TB] FAIL b2b_%0d: got %h want %h", i, obs, e_v[i]);
            else pass_count++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        control = 2'b00;
        a       = '0;
        b       = '0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_logic();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
